ex_stage: RTL and testbench

- Execute stage; consumes ID_EX register outputs, produces ALU result, branch target, zero flag and destination register for EX_MEM.
- Holds architectural HI/LO registers and an iterative divider.
- The divider raises stall_req so the pipeline control logic freezes PC, IF_ID and ID_EX while it runs.

---
 rtl/ex_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage MIPS-style pipeline.
//
// Consumes the ID_EX register outputs and produces the ALU result, zero flag,
// branch target, destination register and store data for EX_MEM. Owns the
// architectural HI/LO registers and an iterative unit shared by div/divu
// (restoring division) and, optionally, mult/multu (shift-add multiply).
// While the iterative unit runs, stall_req freezes PC, IF_ID and ID_EX.
//
// Optional feature macro: EX_MULT_EN -- when defined, funct 0x18/0x19
// (mult/multu) run on the iterative unit with the same stall timing as div.
//
// Parameters:
//   BITS_PER_CYCLE  quotient/product bits resolved per BUSY cycle (1, 2 or 4)
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ex_RegDst       1 = write rd, 0 = write rt
//   ex_ALUOp        00 add, 01 sub, 10 R-type by funct, 11 reserved
//   ex_ALUSrc       1 = operand B is ex_extend, 0 = ex_rdata2
//   ex_pc           PC+4 of the instruction
//   ex_rdata1/2     rs / rt values
//   ex_extend       sign-extended immediate; [5:0] funct, [10:6] shamt
//   ex_rt, ex_rd    register fields
//   flush           kill the instruction currently in EX
//   alu_result      ALU or HI/LO result
//   zero            alu_result == 0
//   branch_target   ex_pc + (ex_extend << 2)
//   write_reg       destination register
//   mem_wdata       ex_rdata2 pass-through
//   stall_req       hold upstream stages this cycle
//   hi_o, lo_o      current HI / LO registers
module ex_stage #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_RegDst,
  input  logic [1:0]  ex_ALUOp,
  input  logic        ex_ALUSrc,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rdata1,
  input  logic [31:0] ex_rdata2,
  input  logic [31:0] ex_extend,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] branch_target,
  output logic [4:0]  write_reg,
  output logic [31:0] mem_wdata,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         ITERS    = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_DIV  = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a, F_SLTU = 6'h2b;
`ifdef EX_MULT_EN
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
`endif

  state_t      state, state_next;
  logic [31:0] hi, lo;
  logic [4:0]  counter;
  logic [32:0] acc;      // partial remainder (div) / upper product half (mult)
  logic [31:0] shreg;    // dividend->quotient (div) / multiplier->lower half (mult)
  logic [31:0] opnd;     // divisor magnitude (div) / multiplicand magnitude (mult)
  logic        neg_q;    // negate quotient (or product) at the end
  logic        neg_r;    // negate remainder at the end
`ifdef EX_MULT_EN
  logic        op_mul;
  logic        mul_funct;
  logic [32:0] sum;
  logic [63:0] prod;
`endif

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b;
  logic        long_funct, long_op, start, is_signed, last_iter;
  logic [31:0] a_mag, b_mag;
  logic [32:0] acc_n;
  logic [31:0] shreg_n, hi_n, lo_n;

  assign funct = ex_extend[5:0];
  assign shamt = ex_extend[10:6];
  assign op_a  = ex_rdata1;
  assign op_b  = ex_ALUSrc ? ex_extend : ex_rdata2;

`ifdef EX_MULT_EN
  assign mul_funct  = (funct == F_MULT) || (funct == F_MULTU);
  assign long_funct = (funct == F_DIV) || (funct == F_DIVU) || mul_funct;
`else
  assign long_funct = (funct == F_DIV) || (funct == F_DIVU);
`endif
  assign long_op   = (ex_ALUOp == 2'b10) && long_funct && !flush;
  assign start     = (state == IDLE) && long_op;
  assign last_iter = (counter == LAST_CNT);

  // Even functs (div, mult) are signed; odd ones (divu, multu) unsigned.
  assign is_signed = !funct[0];
  assign a_mag     = (is_signed && ex_rdata1[31]) ? -ex_rdata1 : ex_rdata1;
  assign b_mag     = (is_signed && ex_rdata2[31]) ? -ex_rdata2 : ex_rdata2;

  // ---------------- combinational datapath ----------------
  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path through the block can leave it holding its old value (latch).
  always_comb begin
    alu_result = '0;
    case (ex_ALUOp)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b10: begin
        case (funct)
          F_ADD, F_ADDU: alu_result = op_a + op_b;
          F_SUB, F_SUBU: alu_result = op_a - op_b;
          F_AND:         alu_result = op_a & op_b;
          F_OR:          alu_result = op_a | op_b;
          F_XOR:         alu_result = op_a ^ op_b;
          F_NOR:         alu_result = ~(op_a | op_b);
          F_SLT:         alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
          F_SLTU:        alu_result = {31'b0, op_a < op_b};
          F_SLL:         alu_result = ex_rdata2 << shamt;
          F_SRL:         alu_result = ex_rdata2 >> shamt;
          F_SRA:         alu_result = $unsigned($signed(ex_rdata2) >>> shamt);
          F_MFHI:        alu_result = hi;
          F_MFLO:        alu_result = lo;
          default:       alu_result = '0;  // div/mult start and unknown functs
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign branch_target = ex_pc + {ex_extend[29:0], 2'b00};
  assign write_reg     = ex_RegDst ? ex_rd : ex_rt;
  assign mem_wdata     = ex_rdata2;
  assign hi_o          = hi;
  assign lo_o          = lo;

  // One BUSY cycle worth of iterations, unrolled BITS_PER_CYCLE times.
  // NOTE: blocking assignments chain the unrolled steps within one cycle;
  // the registers themselves are only updated with <= in always_ff.
  always_comb begin
    acc_n   = acc;
    shreg_n = shreg;
`ifdef EX_MULT_EN
    sum     = '0;
`endif
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef EX_MULT_EN
      if (op_mul) begin
        // Add multiplicand on a set LSB, then shift the 65-bit {carry,acc,shreg} right.
        sum     = {1'b0, acc_n[31:0]} + (shreg_n[0] ? {1'b0, opnd} : 33'd0);
        acc_n   = {1'b0, sum[32:1]};
        shreg_n = {sum[0], shreg_n[31:1]};
      end else
`endif
      begin
        // Restoring step: shift in the next dividend bit, subtract if it fits.
        acc_n   = {acc_n[31:0], shreg_n[31]};
        shreg_n = {shreg_n[30:0], 1'b0};
        if (acc_n >= {1'b0, opnd}) begin
          acc_n      = acc_n - {1'b0, opnd};
          shreg_n[0] = 1'b1;
        end
      end
    end
  end

  // Sign correction and the divide-by-zero convention (LO all ones; HI
  // returns the dividend, which the remainder correction already yields).
  always_comb begin
    hi_n = neg_r ? -acc_n[31:0] : acc_n[31:0];
    lo_n = (opnd == '0) ? '1 : (neg_q ? -shreg_n : shreg_n);
`ifdef EX_MULT_EN
    prod = {acc_n[31:0], shreg_n};
    if (op_mul) {hi_n, lo_n} = neg_q ? -prod : prod;
`endif
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (flush) state_next = IDLE;
               else if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_req = start || (state == BUSY);
  end

  // ---------------- registered datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      acc     <= '0;
      shreg   <= '0;
      opnd    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`ifdef EX_MULT_EN
      op_mul  <= 1'b0;
`endif
    end else if (start) begin
      counter <= '0;
      acc     <= '0;
      shreg   <= a_mag;
      opnd    <= b_mag;
      neg_q   <= is_signed && (ex_rdata1[31] ^ ex_rdata2[31]);
      neg_r   <= is_signed && ex_rdata1[31];
`ifdef EX_MULT_EN
      op_mul  <= mul_funct;
`endif
    end else if (state == BUSY) begin
      counter <= counter + 5'd1;
      acc     <= acc_n;
      shreg   <= shreg_n;
      // An abort in the final cycle wins: HI/LO keep their old values.
      if (last_iter && !flush) begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- self-checking bench for ex_stage.
// Stimulus pushes expected results into scoreboard queues; two monitors pop
// and compare: one for single-cycle ALU instructions, one that measures each
// stall_req run and the HI/LO values left behind by long operations.
module tb_ex_stage;
  localparam int BPC      = 1;
  localparam int LONG_CYC = 32 / BPC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_RegDst, ex_ALUSrc, flush;
  logic [1:0]  ex_ALUOp;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_extend;
  logic [4:0]  ex_rt, ex_rd;
  logic [31:0] alu_result, branch_target, mem_wdata, hi_o, lo_o;
  logic        zero, stall_req;
  logic [4:0]  write_reg;

  ex_stage #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp),
    .ex_ALUSrc(ex_ALUSrc), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_extend(ex_extend), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .flush(flush), .alu_result(alu_result), .zero(zero),
    .branch_target(branch_target), .write_reg(write_reg), .mem_wdata(mem_wdata),
    .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res, bt, wd, hi, lo;
    logic [4:0]  wr;
  } alu_exp_t;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] hi, lo;
  } long_exp_t;

  alu_exp_t  alu_q[$];
  long_exp_t long_q[$];
  alu_exp_t  ae;
  long_exp_t le;
  int        n_cmp = 0;
  int        n_bad = 0;
  int        run   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic src,
                                          input logic [31:0] a, input logic [31:0] r2,
                                          input logic [31:0] ext,
                                          input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] b;
    int sa, sb, sr, sh;
    b  = src ? ext : r2;
    sa = a; sb = b; sr = r2; sh = int'(ext[10:6]);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return 32'd0;
      default:
        case (ext[5:0])
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
          6'h2b: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return r2 << sh;
          6'h02: return r2 >> sh;
          6'h03: return sr >>> sh;
          6'h10: return hi;
          6'h12: return lo;
          default: return 32'd0;
        endcase
    endcase
  endfunction

  task automatic ref_long(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0; el = '0;
    if (fn == 6'h1a || fn == 6'h1b) begin
      if (b == 32'd0) begin
        el = '1; eh = a;
      end else if (fn == 6'h1a) begin
        q = sa / sb; r = sa % sb;
        el = q[31:0]; eh = r[31:0];
      end else begin
        el = a / b; eh = a % b;
      end
    end else if (fn == 6'h18) begin
      p = sa * sb;
      {eh, el} = p;
    end else begin
      up = {32'b0, a} * {32'b0, b};
      {eh, el} = up;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    ex_RegDst = 0; ex_ALUOp = 2'b00; ex_ALUSrc = 0; ex_pc = '0;
    ex_rdata1 = '0; ex_rdata2 = '0; ex_extend = '0; ex_rt = '0; ex_rd = '0;
  endtask

  task automatic expect_alu(input string name, input logic [1:0] op, input logic src,
                            input logic regdst, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] ext, input logic [4:0] rt, input logic [4:0] rd);
    alu_exp_t e;
    e.name = name;
    e.res  = ref_alu(op, src, r1, r2, ext, m_hi, m_lo);
    e.bt   = pc + ext * 32'd4;
    e.wd   = r2;
    e.wr   = regdst ? rd : rt;
    e.hi   = m_hi;
    e.lo   = m_lo;
    alu_q.push_back(e);
  endtask

  task automatic alu(input string name, input logic [1:0] op, input logic src,
                     input logic regdst, input logic [31:0] pc,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] ext, input logic [4:0] rt, input logic [4:0] rd);
    wait_edge();
    ex_ALUOp = op; ex_ALUSrc = src; ex_RegDst = regdst; ex_pc = pc;
    ex_rdata1 = r1; ex_rdata2 = r2; ex_extend = ext; ex_rt = rt; ex_rd = rd;
    expect_alu(name, op, src, regdst, pc, r1, r2, ext, rt, rd);
  endtask

  // Long op (div/divu/mult/multu). abort_at>0 kills it after that many BUSY
  // cycles, by flush (use_rst=0) or by an asynchronous reset pulse (use_rst=1).
  // Returns during the DONE cycle so the next call issues right behind it.
  task automatic run_long(input string name, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input bit use_rst);
    long_exp_t e;
    logic [31:0] eh, el;
    int guard;
    ref_long(fn, a, b, eh, el);
    e.name = name;
    if (abort_at > 0) begin
      e.cycles = use_rst ? abort_at : abort_at + 1;
      eh = use_rst ? 32'd0 : m_hi;
      el = use_rst ? 32'd0 : m_lo;
    end else begin
      e.cycles = LONG_CYC;
    end
    e.hi = eh; e.lo = el;
    long_q.push_back(e);

    wait_edge();
    nop();
    ex_ALUOp = 2'b10; ex_rdata1 = a; ex_rdata2 = b; ex_extend = {26'b0, fn};
    ex_RegDst = 1; ex_rd = 5'd3;
    if (abort_at > 0) begin
      repeat (abort_at) wait_edge();
      if (use_rst) begin
        rst = 1; nop(); #1 rst = 0;
      end else begin
        flush = 1; wait_edge(); flush = 0; nop();
      end
    end else begin
      guard = 0;
      do begin
        wait_edge();
        guard++;
      end while (stall_req && guard < 200);
      if (guard >= 200) begin
        $display("FAIL %s: stall_req never dropped", name);
        n_bad++;
        nop();
      end
    end
    m_hi = eh; m_lo = el;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    while (alu_q.size() > 0) begin
      ae = alu_q.pop_front();
      check({ae.name, "/result"}, 64'(alu_result),    64'(ae.res));
      check({ae.name, "/zero"},   64'(zero),          64'(ae.res == 32'd0));
      check({ae.name, "/btgt"},   64'(branch_target), 64'(ae.bt));
      check({ae.name, "/wreg"},   64'(write_reg),     64'(ae.wr));
      check({ae.name, "/wdata"},  64'(mem_wdata),     64'(ae.wd));
      check({ae.name, "/hi"},     64'(hi_o),          64'(ae.hi));
      check({ae.name, "/lo"},     64'(lo_o),          64'(ae.lo));
      check({ae.name, "/stall"},  64'(stall_req),     64'd0);
    end
  end

  always @(negedge clk) begin
    if (stall_req) begin
      run++;
      if (run == 300) check("stall_timeout", 64'(run), 64'(LONG_CYC));
    end else if (run > 0) begin
      if (long_q.size() == 0) begin
        check("unexpected_stall", 64'(run), 64'd0);
      end else begin
        le = long_q.pop_front();
        check({le.name, "/stall_cycles"}, 64'(run),  64'(le.cycles));
        check({le.name, "/hi"},           64'(hi_o), 64'(le.hi));
        check({le.name, "/lo"},           64'(lo_o), 64'(le.lo));
      end
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [5:0] fset [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3f, 6'h05};

  initial begin
    logic [31:0] ra, rb, ext;
    logic [1:0]  op;
    rst = 1; flush = 0; nop();
    #2 expect_alu("reset", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #10 rst = 0;

    alu("add_imm",  2'b00, 1, 0, 32'h0,   32'd5, 32'd0, 32'hFFFFFFFD, 5'd1, 5'd2);
    alu("sub_zero", 2'b01, 0, 1, 32'h40,  32'd7, 32'd7, 32'h0,        5'd3, 5'd9);
    alu("branch",   2'b00, 1, 0, 32'h100, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd4, 5'd5);
    alu("slt",      2'b10, 0, 1, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h2a, 5'd6, 5'd7);
    alu("sltu",     2'b10, 0, 1, 32'h8, 32'hFFFFFFFF, 32'd1, 32'h2b, 5'd6, 5'd7);
    alu("sra4",     2'b10, 0, 1, 32'h8, 32'h0, 32'h80000000, 32'h103, 5'd6, 5'd8);
    alu("reserved", 2'b11, 0, 0, 32'h8, 32'h3, 32'h4, 32'h20, 5'd6, 5'd8);

    run_long("div_m7_2", 6'h1a, 32'hFFFFFFF9, 32'd2, 0, 0);
    alu("mflo_after_div", 2'b10, 0, 1, 0, 0, 0, 32'h12, 0, 5'd4);
    alu("mfhi_after_div", 2'b10, 0, 1, 0, 0, 0, 32'h10, 0, 5'd4);

    run_long("divu_by0", 6'h1b, 32'h1234, 32'd0, 0, 0);
    alu("mfhi_by0", 2'b10, 0, 1, 0, 0, 0, 32'h10, 0, 5'd4);

    run_long("div_flush10", 6'h1a, 32'd100, 32'd7, 10, 0);
    alu("mflo_after_flush", 2'b10, 0, 1, 0, 0, 0, 32'h12, 0, 5'd4);
    run_long("div_flush_last", 6'h1a, 32'd100, 32'd7, LONG_CYC - 1, 0);

    run_long("div_ovf", 6'h1a, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_long("div_by0_neg", 6'h1a, 32'hFFFFFF00, 32'd0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_long($sformatf("rand_div%0d", i), ($urandom_range(0, 1) == 1) ? 6'h1a : 6'h1b,
               ra, rb, 0, 0);
    end

    run_long("div_rst", 6'h1b, 32'd1000, 32'd3, 5, 1);
    alu("mfhi_after_rst", 2'b10, 0, 1, 0, 0, 0, 32'h10, 0, 5'd4);

`ifdef EX_MULT_EN
    run_long("mult", 6'h18, 32'hFFFFFFFF, 32'd2, 0, 0);
    run_long("multu", 6'h19, 32'hFFFFFFFF, 32'd2, 0, 0);
    alu("mfhi_after_multu", 2'b10, 0, 1, 0, 0, 0, 32'h10, 0, 5'd4);
    for (int i = 0; i < 4; i++)
      run_long($sformatf("rand_mul%0d", i), ($urandom_range(0, 1) == 1) ? 6'h18 : 6'h19,
               $urandom, $urandom, 0, 0);
`else
    alu("mult_disabled",  2'b10, 0, 1, 0, 32'hFFFFFFFF, 32'd2, 32'h18, 0, 5'd4);
    alu("multu_disabled", 2'b10, 0, 1, 0, 32'hFFFFFFFF, 32'd2, 32'h19, 0, 5'd4);
`endif

    for (int i = 0; i < 80; i++) begin
      op  = 2'($urandom_range(0, 3));
      ext = $urandom;
      if (op == 2'b10) ext[5:0] = fset[$urandom_range(0, 16)];
      alu($sformatf("rand_alu%0d", i), op, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, ext,
          5'($urandom), 5'($urandom));
    end

    wait_edge(); nop();
    repeat (3) wait_edge();
    check("alu_queue_drained",  64'(alu_q.size()),  64'd0);
    check("long_queue_drained", 64'(long_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
